// File: rtl/edge_generator_if.sv
// Request/level bundle for edge_generator: the requester drives rise/fall pulses,
// the generator returns the level plus busy and drop status, one bit per lane.
`timescale 1ns/1ps
interface edge_generator_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] pos_req;
  logic [WIDTH-1:0] neg_req;
  logic [WIDTH-1:0] signal;
  logic [WIDTH-1:0] busy;
  logic [WIDTH-1:0] drop;

  modport master (
    output pos_req,
    output neg_req,
    input  signal,
    input  busy,
    input  drop
  );

  modport slave (
    input  pos_req,
    input  neg_req,
    output signal,
    output busy,
    output drop
  );
endinterface

// File: rtl/edge_generator.sv
// Per-lane request-driven level generator: each accepted rise/fall request toggles a
// registered level, which then holds for MIN_HOLD cycles with room for one queued request.
`timescale 1ns/1ps
module edge_generator #(
  parameter int WIDTH      = 1,
  parameter int MIN_HOLD   = 4,
  parameter bit INIT_LEVEL = 1'b0
) (
  input logic             clk,
  input logic             rst,
  edge_generator_if.slave bus
);

  localparam int CW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(MIN_HOLD - 1);

  logic [WIDTH-1:0] sig_q, sig_d;
  logic [WIDTH-1:0] pend_vld_q, pend_vld_d;
  logic [WIDTH-1:0] pend_lvl_q, pend_lvl_d;
  logic [WIDTH-1:0] drop_q, drop_d;
  logic [WIDTH-1:0] busy_c;
  logic [WIDTH-1:0] req_vld, req_lvl, conflict;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  assign req_vld  = bus.pos_req ^ bus.neg_req;
  assign req_lvl  = bus.pos_req;
  assign conflict = bus.pos_req & bus.neg_req;

  // With the hold expired a fresh request beats the queued one; during the hold
  // the newest request simply replaces whatever is queued.
  always_comb begin
    sig_d      = sig_q;
    pend_vld_d = pend_vld_q;
    pend_lvl_d = pend_lvl_q;
    drop_d     = conflict;
    busy_c     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i]  = cnt_q[i];
      busy_c[i] = (cnt_q[i] != '0) | pend_vld_q[i];
      if (cnt_q[i] == '0) begin
        pend_vld_d[i] = 1'b0;
        if (req_vld[i] && pend_vld_q[i] && (pend_lvl_q[i] != req_lvl[i]))
          drop_d[i] = 1'b1;
        if ((req_vld[i] && (req_lvl[i] != sig_q[i])) ||
            (!req_vld[i] && pend_vld_q[i] && (pend_lvl_q[i] != sig_q[i]))) begin
          sig_d[i] = ~sig_q[i];
          cnt_d[i] = HOLD_LOAD;
        end
      end else begin
        cnt_d[i] = cnt_q[i] - CW'(1);
        if (req_vld[i]) begin
          pend_vld_d[i] = 1'b1;
          pend_lvl_d[i] = req_lvl[i];
          if (pend_vld_q[i] && (pend_lvl_q[i] != req_lvl[i]))
            drop_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q      <= {WIDTH{INIT_LEVEL}};
      pend_vld_q <= '0;
      pend_lvl_q <= '0;
      drop_q     <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sig_q      <= sig_d;
      pend_vld_q <= pend_vld_d;
      pend_lvl_q <= pend_lvl_d;
      drop_q     <= drop_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.signal = sig_q;
  assign bus.busy   = busy_c;
  assign bus.drop   = drop_q;

endmodule

// File: tb/tb_edge_generator.sv
// Scoreboard bench for edge_generator: directed vectors queue hand-computed
// expectations that a monitor checks one cycle later, plus an edge-detector loopback.
`timescale 1ns/1ps
module tb_edge_generator;

  typedef struct {
    string      name;
    logic [1:0] sig;
    logic [1:0] busy;
    logic [1:0] drop;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t sb_h1_q[$];

  edge_generator_if #(.WIDTH(2)) bus ();
  edge_generator_if #(.WIDTH(1)) bus1 ();

  edge_generator #(.WIDTH(2), .MIN_HOLD(4), .INIT_LEVEL(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  edge_generator #(.WIDTH(1), .MIN_HOLD(1), .INIT_LEVEL(1'b0)) u_dut_h1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of requests and queue what the outputs must be after that edge.
  task automatic apply_stimulus(input string name, input logic [1:0] p, input logic [1:0] n,
                                input logic [1:0] es, input logic [1:0] eb, input logic [1:0] ed);
    exp_t e;
    @(negedge clk);
    bus.pos_req = p;
    bus.neg_req = n;
    e.name = name; e.sig = es; e.busy = eb; e.drop = ed;
    sb_q.push_back(e);
  endtask

  task automatic idle(input logic [1:0] es, input logic [1:0] eb);
    apply_stimulus("idle", 2'b00, 2'b00, es, eb, 2'b00);
  endtask

  task automatic apply_h1(input string name, input logic p, input logic n,
                          input logic es, input logic ed);
    exp_t e;
    @(negedge clk);
    bus1.pos_req = p;
    bus1.neg_req = n;
    e.name = name; e.sig = {1'b0, es}; e.busy = 2'b00; e.drop = {1'b0, ed};
    sb_h1_q.push_back(e);
  endtask

  // Monitor: one queued expectation per edge, checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_output({e.name, "_signal"}, 32'(bus.signal), 32'(e.sig));
        check_output({e.name, "_busy"},   32'(bus.busy),   32'(e.busy));
        check_output({e.name, "_drop"},   32'(bus.drop),   32'(e.drop));
      end
      if (sb_h1_q.size() > 0) begin
        e = sb_h1_q.pop_front();
        check_output({e.name, "_signal"}, 32'(bus1.signal), 32'(e.sig));
        check_output({e.name, "_busy"},   32'(bus1.busy),   32'(e.busy));
        check_output({e.name, "_drop"},   32'(bus1.drop),   32'(e.drop));
      end
    end
  end

  // Downstream edge detector on lane 0 for the loopback run.
  logic lb_en = 1'b0;
  logic lb_prev = 1'b0;
  int   lb_cyc = 0;
  int   lb_edges = 0;
  int   lb_last = -1;
  int   lb_min_gap = 1000;
  always @(posedge clk) begin
    if (lb_en && (bus.signal[0] !== lb_prev)) begin
      lb_edges++;
      if (lb_last >= 0 && (lb_cyc - lb_last) < lb_min_gap) lb_min_gap = lb_cyc - lb_last;
      lb_last = lb_cyc;
    end
    lb_prev = bus.signal[0];
    lb_cyc++;
  end

  initial begin
    logic lvl;
    logic model_lvl;
    int   toggles;
    int   gap;
    rst = 1'b0;
    bus.pos_req = '0;  bus.neg_req = '0;
    bus1.pos_req = '0; bus1.neg_req = '0;

    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_output("reset_signal", 32'(bus.signal), 32'h3);
    check_output("reset_busy",   32'(bus.busy),   32'h0);
    check_output("reset_drop",   32'(bus.drop),   32'h0);
    check_output("reset_h1_signal", 32'(bus1.signal), 32'h0);
    @(negedge clk) rst = 1'b0;

    apply_stimulus("noop_pos", 2'b01, 2'b00, 2'b11, 2'b00, 2'b00);
    apply_stimulus("go_low",   2'b00, 2'b01, 2'b10, 2'b01, 2'b00);
    idle(2'b10, 2'b01); idle(2'b10, 2'b01); idle(2'b10, 2'b00);

    apply_stimulus("a_rise", 2'b01, 2'b00, 2'b11, 2'b01, 2'b00);
    apply_stimulus("a_neg",  2'b00, 2'b01, 2'b11, 2'b01, 2'b00);
    idle(2'b11, 2'b01); idle(2'b11, 2'b01);
    apply_stimulus("a_fall", 2'b00, 2'b00, 2'b10, 2'b01, 2'b00);
    idle(2'b10, 2'b01); idle(2'b10, 2'b01); idle(2'b10, 2'b00);

    apply_stimulus("b_rise",  2'b01, 2'b00, 2'b11, 2'b01, 2'b00);
    apply_stimulus("b_neg",   2'b00, 2'b01, 2'b11, 2'b01, 2'b00);
    apply_stimulus("b_pos",   2'b01, 2'b00, 2'b11, 2'b01, 2'b01);
    idle(2'b11, 2'b01);
    apply_stimulus("b_clear", 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);

    apply_stimulus("c_conf", 2'b10, 2'b10, 2'b11, 2'b00, 2'b10);
    idle(2'b11, 2'b00);

    apply_stimulus("d_low",  2'b00, 2'b01, 2'b10, 2'b01, 2'b00);
    apply_stimulus("d_pos",  2'b01, 2'b00, 2'b10, 2'b01, 2'b00);
    idle(2'b10, 2'b01); idle(2'b10, 2'b01);
    apply_stimulus("d_rise", 2'b00, 2'b00, 2'b11, 2'b01, 2'b00);
    apply_stimulus("d_neg",  2'b00, 2'b01, 2'b11, 2'b01, 2'b00);
    idle(2'b11, 2'b01); idle(2'b11, 2'b01);
    apply_stimulus("d_expiry", 2'b01, 2'b00, 2'b11, 2'b00, 2'b01);
    idle(2'b11, 2'b00);

    apply_stimulus("e_low",  2'b00, 2'b01, 2'b10, 2'b01, 2'b00);
    apply_stimulus("e_pos",  2'b01, 2'b00, 2'b10, 2'b01, 2'b00);
    idle(2'b10, 2'b01); idle(2'b10, 2'b01);
    apply_stimulus("e_rise", 2'b00, 2'b00, 2'b11, 2'b01, 2'b00);
    apply_stimulus("e_neg",  2'b00, 2'b01, 2'b11, 2'b01, 2'b00);
    idle(2'b11, 2'b01); idle(2'b11, 2'b01);
    apply_stimulus("e_fall", 2'b00, 2'b00, 2'b10, 2'b01, 2'b00);
    idle(2'b10, 2'b01); idle(2'b10, 2'b01); idle(2'b10, 2'b00);

    apply_stimulus("r_hi",   2'b01, 2'b00, 2'b11, 2'b01, 2'b00);
    idle(2'b11, 2'b01); idle(2'b11, 2'b01); idle(2'b11, 2'b00);
    apply_stimulus("r_lo",   2'b00, 2'b01, 2'b10, 2'b01, 2'b00);
    apply_stimulus("r_pend", 2'b01, 2'b00, 2'b10, 2'b01, 2'b00);
    @(posedge clk);
    #2;
    bus.pos_req = '0; bus.neg_req = '0;
    rst = 1'b1;
    #1;
    check_output("midhold_reset_signal", 32'(bus.signal), 32'h3);
    check_output("midhold_reset_busy",   32'(bus.busy),   32'h0);
    check_output("midhold_reset_drop",   32'(bus.drop),   32'h0);
    @(negedge clk) rst = 1'b0;
    apply_stimulus("r_after", 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);

    model_lvl = 1'b1;
    toggles = 0;
    @(negedge clk) lb_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      lvl = 1'($urandom_range(0, 1));
      bus.pos_req = {1'b0, lvl};
      bus.neg_req = {1'b0, ~lvl};
      if (lvl != model_lvl) toggles++;
      model_lvl = lvl;
      gap = int'($urandom_range(4, 7));
      for (int j = 1; j < gap; j++) begin
        @(negedge clk);
        bus.pos_req = '0; bus.neg_req = '0;
      end
    end
    repeat (3) @(negedge clk);
    lb_en = 1'b0;
    check_output("lb_edge_count", 32'(lb_edges), 32'(toggles));
    check_output("lb_min_gap_ok", 32'(lb_min_gap >= 4), 32'h1);
    check_output("lb_final_level", 32'(bus.signal[0]), 32'(model_lvl));

    apply_h1("h1_rise",  1'b1, 1'b0, 1'b1, 1'b0);
    apply_h1("h1_fall",  1'b0, 1'b1, 1'b0, 1'b0);
    apply_h1("h1_rise2", 1'b1, 1'b0, 1'b1, 1'b0);
    apply_h1("h1_same",  1'b1, 1'b0, 1'b1, 1'b0);
    apply_h1("h1_conf",  1'b1, 1'b1, 1'b1, 1'b1);
    apply_h1("h1_fall2", 1'b0, 1'b1, 1'b0, 1'b0);
    apply_h1("h1_idle",  1'b0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0 || sb_h1_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: actual %0d entries left required 0",
               sb_q.size() + sb_h1_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_generator.md
# edge_generator

Request-driven level generator, the transmit-side counterpart of the team's edge detector. Each bit takes one-cycle rise/fall request pulses and drives a registered, glitch-free level. Each new level is held for at least `MIN_HOLD` cycles, and one request that arrives during the hold is queued. Its `signal` output feeds edge-detecting consumers directly, so one accepted request produces exactly one detected edge downstream.

## Interface
- `WIDTH`, default 1: number of independent bit lanes.
- `MIN_HOLD`, default 4: minimum cycles a level persists after an edge; legal range ≥1.
- `INIT_LEVEL`, default 0: reset value of every lane of `signal`.
- `clk`, input, 1: the single clock. All state updates on its rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `pos_req`, input, WIDTH: per-lane request to drive the level high, one-cycle pulse.
- `neg_req`, input, WIDTH: per-lane request to drive the level low, one-cycle pulse.
- `signal`, output, WIDTH: registered generated level.
- `busy`, output, WIDTH: lane is holding or has a queued request.
- `drop`, output, WIDTH: one-cycle pulse when a request is discarded without ever taking effect.

## Operation
- Lanes are fully independent. Per lane the state is: `signal` bit, hold counter `cnt` (width `$clog2(MIN_HOLD)`, minimum 1), `pend_vld`, and `pend_lvl`.
- Lane states:
  - IDLE: `cnt==0`, `pend_vld==0`.
  - HOLD: `cnt!=0`, `pend_vld==0`.
  - HOLD_PEND: `cnt!=0`, `pend_vld==1`.
  - `pend_vld` set with `cnt==0` exists only transiently and is resolved on the next edge.
- Request decode:
  - `req_vld = pos_req ^ neg_req`; `req_lvl = pos_req`.
  - `pos_req & neg_req` counts as a conflict: the request is ignored and `drop` is asserted.
- Effective target on an edge with `cnt==0`:
  - If `req_vld`, the target is `req_lvl`.
  - Otherwise, if `pend_vld`, the target is `pend_lvl`.
  - Otherwise there is no target.
  - If a valid request overrides a pending request with a different level, `drop` is asserted.
- Toggle, taken when a target exists and differs from `signal`:
  - `signal` inverts.
  - `cnt` loads `MIN_HOLD-1`.
  - `pend_vld` clears.
- No toggle when the target equals `signal`: `pend_vld` clears and `cnt` stays 0.
- Request during the hold (`cnt!=0`) with `req_vld`:
  - `pend_vld` is set to 1 and `pend_lvl` is set to `req_lvl`.
  - If a pending request already existed with a different `pend_lvl`, `drop` is asserted.
  - A queued request whose level equals the current `signal` cancels any opposite pending request; it then resolves as a no-op.
- The hold counter decrements by 1 each edge while `cnt!=0`, and saturates at 0.
- Output decode:
  - `busy = (cnt!=0) | pend_vld`, combinational from registers.
  - `drop` is registered.

## Timing
- Reset values while `rst` is asserted:
  - `signal` = `{WIDTH{INIT_LEVEL}}`.
  - `cnt`, `pend_vld`, `pend_lvl`, `busy`, `drop` are all 0.
- Reset is asynchronous, so outputs change immediately without waiting for a clock edge.
- A reset asserted mid-hold or with a pending request discards all state and does not pulse `drop`.
- Latency: a request sampled at edge N in IDLE changes `signal` at edge N, so the change is visible in cycle N+1.
- Hold: after a toggle at edge N, the earliest next toggle is at edge N+MIN_HOLD. Each level therefore lasts at least `MIN_HOLD` cycles.
- A pending request resolves at the first edge where `cnt==0`. It toggles exactly at edge N+MIN_HOLD, provided no new request arrives that cycle.
- `MIN_HOLD=1`: `cnt` never leaves 0, and every valid request that differs from the current level toggles immediately (one edge per cycle maximum).
- `drop` is asserted in the cycle after the edge that sampled the offending request, for exactly one cycle per event.

## Test plan
- Reset with `INIT_LEVEL=1`, `WIDTH=2`, `MIN_HOLD=4`:
  - Assert `rst` mid-cycle -> `signal=2'b11` immediately, `busy=0`, `drop=0`.
  - Deassert, then `pos_req=2'b01` -> no change, `drop=0`.
- Lane 0 starts at 0. Pulse `pos_req[0]` at edge 0, then `neg_req[0]` at edge 1:
  - `signal[0]` rises after edge 0, holds high for cycles 1–4, and falls after edge 4.
  - `busy[0]` stays 1 until the fall, then is 1 again for the new hold.
  - `drop=0` throughout.
- Overwrite during hold:
  - Toggle high at edge 0, then `neg_req` at edge 1, then `pos_req` at edge 2.
  - `drop[0]` asserts at cycle 3 for one cycle; `signal[0]` stays high and `busy[0]` clears after edge 4.
- Conflict: `pos_req[1]=neg_req[1]=1` in IDLE -> `signal[1]` unchanged, `drop[1]` asserts for one cycle, lane 0 unaffected.
- Priority at hold expiry:
  - Pending low plus a new `pos_req` arriving at the expiry edge -> `signal` stays high and `drop` asserts.
  - Pending low alone at expiry -> falls at exactly edge N+4.
- Loopback: connect `signal` to an edge detector and issue 10 random legal requests -> the count of `pos_edge` plus `neg_edge` equals the number of toggles predicted by the model, and no edges are spaced closer than 4 cycles.
